// File: rtl/instr_mem_pkg.sv
// Shared definitions for the loadable instruction memory: HALT encoding and
// the control state enumeration.
package instr_mem_pkg;

    localparam logic [3:0]  OP_HALT       = 4'b1111;
    localparam logic [15:0] HALT_WORD_DEF = {OP_HALT, 12'h000};

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_IDLE = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

endpackage

// File: rtl/instr_mem_loadable_ram.sv
// Synchronous RAM: one write port, one registered read port. Contents are
// not reset; the owner rewrites every word after reset.
module instr_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory: HALT fill after reset, sequential
// load stream, one-cycle-latency fetch port.
//
// Handshakes: a load word transfers on a rising edge where load_valid and
// load_ready are both high; a fetch is accepted on a rising edge where
// fetch_req and fetch_ready are both high, and answers with a one-cycle
// fetch_valid pulse on the following cycle. Ready signals depend on state only.
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 256,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_full,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_err,
    output logic              busy,
    output state_t            state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_n;
    logic [ADDR_W-1:0] fill_ptr, wr_ptr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              load_acc, load_end;
    logic              fetch_acc, fetch_oor;
    logic              sel_halt;

    assign fetch_oor = ({1'b0, fetch_addr} >= DEPTH_X);
    assign fetch_acc = fetch_req & (state == ST_IDLE);
    assign load_acc  = load_valid & (state == ST_LOAD);

    always_comb begin
        state_n   = state;
        ram_we    = 1'b0;
        ram_waddr = fill_ptr;
        ram_wdata = HALT_WORD;
        load_end  = 1'b0;
        case (state)
            ST_FILL: begin
                ram_we = 1'b1;
                if (fill_ptr == LAST_ADDR) begin
                    state_n = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (load_start) begin
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ram_waddr = wr_ptr;
                ram_wdata = load_data;
                if (load_acc) begin
                    ram_we = 1'b1;
                    if (load_last || (wr_ptr == LAST_ADDR)) begin
                        load_end = 1'b1;
                        state_n  = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_FILL;
        endcase
        // The fill that follows reset rewrites everything, so suppress writes during it.
        if (rst) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FILL;
            fill_ptr    <= '0;
            wr_ptr      <= '0;
            load_done   <= 1'b0;
            load_full   <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            sel_halt    <= 1'b1;
        end else begin
            state <= state_n;
            if (state == ST_FILL) begin
                fill_ptr <= fill_ptr + ADDR_W'(1);
            end
            if ((state == ST_IDLE) && load_start) begin
                wr_ptr <= '0;
            end else if (load_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            load_done   <= load_end;
            load_full   <= load_end & ~load_last;
            fetch_valid <= fetch_acc;
            fetch_err   <= fetch_acc & fetch_oor;
            if (fetch_acc) begin
                sel_halt <= fetch_oor;
            end
        end
    end

    // The RAM read register only moves on in-range fetches, so the output
    // holds its value between responses; sel_halt covers reset and misses.
    assign fetch_instr = sel_halt ? HALT_WORD : ram_rdata;
    assign fetch_ready = (state == ST_IDLE);
    assign load_ready  = (state == ST_LOAD);
    assign busy        = (state != ST_IDLE);
    assign state_dbg   = state;

    instr_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .re   (fetch_acc & ~fetch_oor),
        .raddr(fetch_addr),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable with a small array model of the
// memory contents and randomized load/fetch traffic.
module tb_instr_mem_loadable;
    import instr_mem_pkg::*;

    localparam int          DW    = 16;
    localparam int          AW    = 8;
    localparam int          DEPTH = 200;
    localparam logic [15:0] HALT  = 16'hF000;

    logic          clk;
    logic          rst;
    logic          load_start, load_valid, load_last;
    logic [DW-1:0] load_data;
    logic          load_ready, load_done, load_full;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ready, fetch_valid, fetch_err, busy;
    logic [DW-1:0] fetch_instr;
    state_t        state_dbg;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] ld_buf [DEPTH];
    logic [DW:0]   exp_q [$];
    int            n_checks = 0;
    int            n_pass   = 0;

    instr_mem_loadable #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .HALT_WORD(HALT)
    ) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .load_full(load_full), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .fetch_err(fetch_err), .busy(busy),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW:0] ref_fetch(input logic [AW-1:0] a);
        if (int'(a) >= DEPTH) return {1'b1, HALT};
        return {1'b0, model_mem[a]};
    endfunction

    // monitor: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (fetch_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL fetch_unexpected: got valid with instr %0h, expected no response", fetch_instr);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                check("fetch_instr", 32'(fetch_instr), 32'(e[DW-1:0]));
                check("fetch_err", 32'(fetch_err), 32'(e[DW]));
            end
        end
    end

    // driver tasks
    task automatic do_reset(input bit with_fetch);
        rst = 1'b1;
        if (with_fetch) begin
            fetch_req  = 1'b1;
            fetch_addr = '0;
        end
        tick();
        fetch_req  = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_start = 1'b0;
        check("rst_fetch_valid", 32'(fetch_valid), 0);
        check("rst_fetch_instr", 32'(fetch_instr), 32'(HALT));
        check("rst_fetch_err", 32'(fetch_err), 0);
        check("rst_load_ready", 32'(load_ready), 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_load_full", 32'(load_full), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_fetch_ready", 32'(fetch_ready), 0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = HALT;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            if (i == DEPTH - 1) begin
                check("fill_ready_early", 32'(fetch_ready), 0);
                check("fill_busy_early", 32'(busy), 1);
            end
            if (i == DEPTH) begin
                check("fill_ready_at_depth", 32'(fetch_ready), 1);
                check("fill_busy_at_depth", 32'(busy), 0);
            end
        end
    endtask

    task automatic fetch_issue(input logic [AW-1:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        exp_q.push_back(ref_fetch(a));
        tick();
        fetch_req = 1'b0;
    endtask

    // Streams ld_buf[0..n-1]; poke also tries a fetch and a second
    // load_start mid-load, both of which must be ignored.
    task automatic load_body(input int n, input bit use_last, input bit poke);
        for (int k = 0; k < n; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
            load_valid = 1'b1;
            load_data  = ld_buf[k];
            load_last  = use_last && (k == n - 1);
            if (poke && k == 1) begin
                fetch_req  = 1'b1;
                fetch_addr = 8'd3;
            end
            if (poke && k == n / 2) load_start = 1'b1;
            tick();
            load_valid = 1'b0;
            load_last  = 1'b0;
            load_start = 1'b0;
            fetch_req  = 1'b0;
            if (k < n - 1 && (k == 0 || k == n / 2 + 1)) begin
                check("load_done_early", 32'(load_done), 0);
                check("load_ready_mid", 32'(load_ready), 1);
            end
        end
        for (int k = 0; k < n; k++) model_mem[k] = ld_buf[k];
        check("load_done", 32'(load_done), 1);
        check("load_full", 32'(load_full), 32'(!use_last));
        check("load_end_idle", 32'(fetch_ready), 1);
        tick();
        check("load_done_pulse", 32'(load_done), 0);
    endtask

    task automatic load_words(input int n, input bit use_last, input bit poke);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_ready_start", 32'(load_ready), 1);
        check("load_fetch_blocked", 32'(fetch_ready), 0);
        load_body(n, use_last, poke);
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = '0; fetch_req = 1'b0; fetch_addr = '0;

        do_reset(1'b0);
        fetch_issue(8'd0);
        fetch_issue(8'd5);
        fetch_issue(8'(DEPTH - 1));

        ld_buf[0] = 16'h8123; ld_buf[1] = 16'h0000; ld_buf[2] = 16'h0000; ld_buf[3] = 16'hF000;
        load_words(4, 1'b1, 1'b0);
        fetch_issue(8'd0);
        tick();
        check("fetch_valid_gap", 32'(fetch_valid), 0);
        check("fetch_instr_hold", 32'(fetch_instr), 32'h8123);
        fetch_issue(8'd4);
        fetch_issue(8'd1);

        // fetch and load_start in the same cycle: fetch sees the old word
        fetch_req = 1'b1; fetch_addr = 8'd0; load_start = 1'b1;
        exp_q.push_back(ref_fetch(8'd0));
        tick();
        fetch_req = 1'b0; load_start = 1'b0;
        check("same_cycle_load_ready", 32'(load_ready), 1);
        ld_buf[0] = 16'h1111;
        load_body(1, 1'b1, 1'b0);
        fetch_issue(8'd0);
        fetch_issue(8'd1);

        for (int k = 0; k < DEPTH; k++) ld_buf[k] = 16'($urandom);
        load_words(DEPTH, 1'b0, 1'b1);
        fetch_issue(8'(DEPTH - 1));
        fetch_issue(8'd250);
        fetch_issue(8'd0);
        fetch_issue(8'd1);
        fetch_issue(8'd250);
        for (int i = 0; i < 30; i++) begin
            fetch_issue(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) tick();
        end

        // a fetch coinciding with reset must produce no response
        tick();
        do_reset(1'b1);

        ld_buf[0] = 16'h8123; ld_buf[1] = 16'h4444;
        fetch_issue(8'd0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            load_valid = 1'b1;
            load_data  = ld_buf[k];
            tick();
        end
        load_data = 16'h5555;
        do_reset(1'b0);
        fetch_issue(8'd0);
        fetch_issue(8'd1);

        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, run-time loadable instruction memory for the mini crypto processor. It replaces the fixed, combinational program store with a synchronous-read RAM. The RAM is filled with HALT words after reset, written sequentially over a load stream, and read by the fetch stage over a valid/ready handshake with one-cycle latency. It sits between the boot/host loader and the processor fetch stage.

## Interface
- `DATA_W`, 16, instruction width in bits.
- `ADDR_W`, 8, address width in bits.
- `DEPTH`, 256, number of words; must satisfy 2 ≤ DEPTH ≤ 2**ADDR_W.
- `HALT_WORD`, 16'hF000, fill and out-of-range value; opcode nibble is 4'b1111.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_start`  in  1  pulse; begins a load at address 0 (accepted in IDLE only).
- `load_valid`  in  1  load word present.
- `load_data`  in  DATA_W  word to write.
- `load_last`  in  1  qualifies the final word of the load.
- `load_ready`  out  1  high in LOAD.
- `load_done`  out  1  one-cycle pulse when the load ends.
- `load_full`  out  1  valid with `load_done`; the load ended at DEPTH-1 without `load_last`.
- `fetch_req`  in  1  fetch request.
- `fetch_addr`  in  ADDR_W  fetch address.
- `fetch_ready`  out  1  high in IDLE.
- `fetch_valid`  out  1  read data valid.
- `fetch_instr`  out  DATA_W  read data.
- `fetch_err`  out  1  valid with `fetch_valid`; address ≥ DEPTH.
- `busy`  out  1  high in FILL or LOAD.

## Operation
**States**
- FILL: writes HALT_WORD to address `fill_ptr`, then increments the pointer. On the write to DEPTH-1, go to IDLE.
- IDLE: serves fetches. On `load_start`, go to LOAD and set `wr_ptr` to 0.
- LOAD: on `load_valid & load_ready`, write `load_data` to `wr_ptr`, then increment the pointer.
  - End the load when `load_last` is high or `wr_ptr` = DEPTH-1.
  - On end: pulse `load_done`, set `load_full = !load_last`, go to IDLE.
  - Locations not written keep their prior contents.

**Fetch**
- Accepted on `fetch_req & fetch_ready`.
- In range: `fetch_instr` = mem[`fetch_addr`] on the next cycle.
- `fetch_addr` ≥ DEPTH: return HALT_WORD with `fetch_err` = 1. No memory access.
- `fetch_valid` is a one-cycle pulse per accepted request. Back-to-back requests give back-to-back data.
- `fetch_instr` holds its last value while `fetch_valid` = 0.

**Simultaneous events**
- `fetch_req` and `load_start` in the same IDLE cycle: both are accepted. The fetch returns the pre-load content.
- `load_start` outside IDLE: ignored.
- `fetch_req` outside IDLE: not accepted, no response.

**Reset**
- `rst` at any time, including mid-LOAD or mid-FILL: enter FILL with `fill_ptr` = 0 and drop any in-flight fetch response.
- All words are re-initialised to HALT_WORD.

**Reset values**
- `fetch_valid` 0, `fetch_instr` HALT_WORD, `fetch_err` 0.
- `load_ready` 0, `load_done` 0, `load_full` 0.
- `busy` 1, `fetch_ready` 0.

## Timing
- The first cycle after `rst` deasserts writes address 0. IDLE (`fetch_ready` = 1) begins exactly DEPTH cycles after deassertion.
- Fetch latency is 1 cycle. Throughput is 1 fetch per cycle in IDLE.
- `load_start` in cycle t: `load_ready` = 1 from t+1.
- The final word is accepted in cycle t: `load_done` pulses in t+1, which is the first IDLE cycle.
- A word written in cycle t is readable by a fetch accepted in cycle t+1 or later.
- All outputs are registered or decoded from state only. There is no combinational input-to-output path.

## Structure
- Shared package `instr_mem_pkg`:
  - `OP_HALT` (4'b1111) and the derived `HALT_WORD` default.
  - The state enumeration FILL/IDLE/LOAD.
- Sub-module `instr_ram`: parametrised single-port-write, single-port-read synchronous RAM (DATA_W × DEPTH, one write port, registered read). The control FSM, pointers and range check stay in the top module.

## Test plan
- Reset, then wait DEPTH cycles → `busy` falls at cycle DEPTH. Fetch addresses 0, 5 and DEPTH-1 → each returns 16'hF000 with `fetch_err` = 0.
- Load 4 words (16'h8123, 0, 0, 16'hF000) with `load_last` on the 4th → `load_done` = 1 and `load_full` = 0. Fetch address 0 → 16'h8123; fetch address 4 → 16'hF000.
- Load DEPTH words without `load_last` → `load_done` with `load_full` = 1 after the DEPTH-th word. Fetch DEPTH-1 → last word loaded.
- With DEPTH = 200, fetch address 250 → 16'hF000 with `fetch_err` = 1. Back-to-back fetches of 0, 1, 250 → three consecutive `fetch_valid` pulses with the correct data and error bits.
- Same-cycle `fetch_req(0)` and `load_start`, where mem[0] = 16'h8123 and the new word is 16'h1111 → fetch returns 16'h8123. After the load, fetch 0 → 16'h1111.
- Assert `rst` after 2 of 4 load words → all outputs take reset values next cycle. After the FILL completes, fetch 0 → 16'hF000.
